// File: rtl/req_encoder.sv
// Purpose: registered priority encoder; collects requests into a sticky pending set and presents the lowest unmasked index.
// Latency: a request sampled at edge E0 is presented after edge E1 (2 edges); one bubble cycle follows each ack.
// Backpressure: the presented index is held until ack_in; new requests queue in pending and cannot preempt it.
//
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   req_in       request bits, OR'd into pending on every edge (pulse or level)
//   mask_in      1 = pending bit may be presented, 0 = held pending but not presented
//   ack_in       consumer accepts the presented index; ignored while valid_out=0
//   valid_out    idx_out/onehot_out carry a presented request
//   idx_out      binary index of the presented request
//   onehot_out   decode of idx_out while valid_out=1, otherwise zero
//   pending_out  raw pending register (mask not applied)
module req_encoder #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3     // must equal $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] mask_in,
    input  logic             ack_in,
    output logic             valid_out,
    output logic [IDX_W-1:0] idx_out,
    output logic [N_REQ-1:0] onehot_out,
    output logic [N_REQ-1:0] pending_out
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   pending_q, pending_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_REQ-1:0]   onehot_q, onehot_d;

    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   clr;
    logic               found;
    logic [IDX_W-1:0]   scan_idx;

    // Priority scan: walk from the top down so the lowest set bit is the
    // last one written and therefore wins.
    always_comb begin
        eligible = pending_q & mask_in;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found    = 1'b1;
                scan_idx = IDX_W'(i);
            end
        end
    end

    // Retire the presented request on ack. onehot_q already holds the decode
    // of idx_q while valid, so it doubles as the clear mask. The OR with
    // req_in afterwards lets a request re-raised in its own ack cycle survive.
    always_comb begin
        clr       = (valid_q && ack_in) ? onehot_q : '0;
        pending_d = (pending_q & ~clr) | req_in;
    end

    // Next-state and output logic. In PRESENT the outputs are frozen, so
    // mask or request changes never retract or re-prioritise a presentation.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d    = scan_idx;
                    onehot_d = N_REQ'(1) << scan_idx;
                    valid_d  = 1'b1;
                    state_d  = PRESENT;
                end else begin
                    valid_d  = 1'b0;
                    onehot_d = '0;
                end
            end
            PRESENT: begin
                if (ack_in) begin
                    valid_d  = 1'b0;
                    onehot_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                valid_d  = 1'b0;
                onehot_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            onehot_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            onehot_q  <= onehot_d;
        end
    end

    assign valid_out   = valid_q;
    assign idx_out     = idx_q;
    assign onehot_out  = onehot_q;
    assign pending_out = pending_q;

endmodule

// File: tb/tb_req_encoder.sv
// Purpose: directed self-checking bench for req_encoder (N_REQ=8).
// Latency: inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: ack_in is driven explicitly per vector to hold or release presentations.
module tb_req_encoder;

    logic       clk;
    logic       reset;
    logic [7:0] req_in;
    logic [7:0] mask_in;
    logic       ack_in;
    logic       valid_out;
    logic [2:0] idx_out;
    logic [7:0] onehot_out;
    logic [7:0] pending_out;

    int n_tests;
    int n_fail;

    req_encoder #(.N_REQ(8), .IDX_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_in      (req_in),
        .mask_in     (mask_in),
        .ack_in      (ack_in),
        .valid_out   (valid_out),
        .idx_out     (idx_out),
        .onehot_out  (onehot_out),
        .pending_out (pending_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-edge trace for 0xA4 with ack held high.
    logic       exp_v [6];
    logic [2:0] exp_i [6];
    logic [7:0] exp_p [6];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        req_in  = 8'h00;
        mask_in = 8'hFF;
        ack_in  = 1'b0;

        #1;
        check("rst_valid",   {31'd0, valid_out}, 32'd0);
        check("rst_idx",     {29'd0, idx_out},   32'd0);
        check("rst_onehot",  {24'd0, onehot_out},32'd0);
        check("rst_pending", {24'd0, pending_out},32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Single request: 2-edge latency, then ack retires it.
        req_in = 8'h10;
        tick();
        req_in = 8'h00;
        check("t2_pend_after_e0",  {24'd0, pending_out}, 32'h10);
        check("t2_valid_after_e0", {31'd0, valid_out},   32'd0);
        tick();
        check("t2_valid", {31'd0, valid_out},   32'd1);
        check("t2_idx",   {29'd0, idx_out},     32'd4);
        check("t2_oh",    {24'd0, onehot_out},  32'h10);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        check("t2_valid_ack", {31'd0, valid_out},   32'd0);
        check("t2_pend_ack",  {24'd0, pending_out}, 32'h00);
        check("t2_oh_ack",    {24'd0, onehot_out},  32'h00);

        // 0xA4 with ack held: 2, 5, 7 on alternate cycles.
        exp_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_i = '{3'd2, 3'd2, 3'd5, 3'd5, 3'd7, 3'd7};
        exp_p = '{8'hA4, 8'hA0, 8'hA0, 8'h80, 8'h80, 8'h00};
        req_in = 8'hA4;
        ack_in = 1'b1;
        tick();
        req_in = 8'h00;
        check("t3_pend_e0", {24'd0, pending_out}, 32'hA4);
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("t3_valid_%0d", k), {31'd0, valid_out},   {31'd0, exp_v[k]});
            check($sformatf("t3_pend_%0d", k),  {24'd0, pending_out}, {24'd0, exp_p[k]});
            if (exp_v[k])
                check($sformatf("t3_idx_%0d", k), {29'd0, idx_out}, {29'd0, exp_i[k]});
        end
        ack_in = 1'b0;

        // Masked request stays pending and unpresented until unmasked.
        mask_in = 8'hFB;
        req_in  = 8'h04;
        tick();
        req_in  = 8'h00;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("t4_novalid_%0d", k), {31'd0, valid_out}, 32'd0);
        end
        check("t4_pend", {24'd0, pending_out}, 32'h04);
        mask_in = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            if (!valid_out) tick();
        end
        check("t4_valid", {31'd0, valid_out},  32'd1);
        check("t4_idx",   {29'd0, idx_out},    32'd2);
        check("t4_oh",    {24'd0, onehot_out}, 32'h04);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        check("t4_pend_clr", {24'd0, pending_out}, 32'h00);

        // Request re-raised in its own ack cycle survives and re-presents.
        req_in = 8'h08;
        tick();
        req_in = 8'h00;
        tick();
        check("t5_valid", {31'd0, valid_out}, 32'd1);
        check("t5_idx",   {29'd0, idx_out},   32'd3);
        ack_in = 1'b1;
        req_in = 8'h08;
        tick();
        ack_in = 1'b0;
        req_in = 8'h00;
        check("t5_bubble",   {31'd0, valid_out},   32'd0);
        check("t5_pend_set", {24'd0, pending_out}, 32'h08);
        tick();
        check("t5_valid2", {31'd0, valid_out}, 32'd1);
        check("t5_idx2",   {29'd0, idx_out},   32'd3);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        check("t5_pend_clr", {24'd0, pending_out}, 32'h00);

        // Higher-priority arrival does not preempt a held presentation.
        req_in = 8'h40;
        tick();
        req_in = 8'h00;
        tick();
        check("t6_valid", {31'd0, valid_out}, 32'd1);
        check("t6_idx",   {29'd0, idx_out},   32'd6);
        req_in = 8'h01;
        tick();
        req_in = 8'h00;
        check("t6_pend", {24'd0, pending_out}, 32'h41);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t6_hold_idx_%0d", k), {29'd0, idx_out},    32'd6);
            check($sformatf("t6_hold_oh_%0d", k),  {24'd0, onehot_out}, 32'h40);
        end
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        check("t6_bubble",   {31'd0, valid_out},   32'd0);
        check("t6_pend_ack", {24'd0, pending_out}, 32'h01);
        tick();
        check("t6_valid2", {31'd0, valid_out},  32'd1);
        check("t6_idx2",   {29'd0, idx_out},    32'd0);
        check("t6_oh2",    {24'd0, onehot_out}, 32'h01);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        check("t6_pend_clr", {24'd0, pending_out}, 32'h00);

        // ack while nothing is presented clears nothing.
        mask_in = 8'h00;
        req_in  = 8'h02;
        tick();
        req_in  = 8'h00;
        ack_in  = 1'b1;
        tick();
        tick();
        ack_in  = 1'b0;
        check("idle_ack_pend",  {24'd0, pending_out}, 32'h02);
        check("idle_ack_valid", {31'd0, valid_out},   32'd0);
        mask_in = 8'hFF;
        tick();
        check("idle_ack_idx", {29'd0, idx_out}, 32'd1);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;

        // Asynchronous reset mid-presentation (idx 5, pending 0x60).
        req_in = 8'h60;
        tick();
        req_in = 8'h00;
        tick();
        check("t1_pre_valid", {31'd0, valid_out},   32'd1);
        check("t1_pre_idx",   {29'd0, idx_out},     32'd5);
        check("t1_pre_pend",  {24'd0, pending_out}, 32'h60);
        #3;
        reset = 1'b1;
        #1;
        check("t1_valid",   {31'd0, valid_out},   32'd0);
        check("t1_idx",     {29'd0, idx_out},     32'd0);
        check("t1_oh",      {24'd0, onehot_out},  32'h00);
        check("t1_pending", {24'd0, pending_out}, 32'h00);
        tick();
        reset = 1'b0;
        tick();
        check("t1_after_valid", {31'd0, valid_out}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
